mdu_pipe: RTL and testbench

//   Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage of the pipelined CPU.

---
 rtl/mdu_pipe_pkg.sv | 22 ++
 rtl/mdu_arith.sv | 66 ++++++
 rtl/mdu_pipe.sv | 106 ++++++++++
 tb/tb_mdu_pipe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pipe_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and controller states.
// The hazard unit imports the same package so both agree on the op codes.
package mdu_pipe_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  // Ops that occupy the unit for a latency window and write hi/lo through the shadow regs.
  function automatic logic is_md_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing {res_hi, res_lo}, including the
// divide-by-zero and signed-overflow special results.
module mdu_arith
  import mdu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic                 is_signed;
  logic                 is_div;
  logic                 neg_a;
  logic                 neg_b;
  logic [2*WIDTH-1:0]   mul_a;
  logic [2*WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     quo_u;
  logic [WIDTH-1:0]     rem_u;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;

  // One multiplier and one unsigned divider serve both signed and unsigned forms;
  // signed division works on magnitudes and fixes the signs afterwards.
  always_comb begin
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    is_div    = (op == MD_DIV) || (op == MD_DIVU);
    neg_a     = is_signed & src_a[WIDTH-1];
    neg_b     = is_signed & src_b[WIDTH-1];

    mul_a = {{WIDTH{neg_a}}, src_a};
    mul_b = {{WIDTH{neg_b}}, src_b};
    prod  = mul_a * mul_b;

    mag_a = neg_a ? -src_a : src_a;
    mag_b = neg_b ? -src_b : src_b;
    quo_u = mag_a / mag_b;
    rem_u = mag_a % mag_b;
    quo   = (neg_a ^ neg_b) ? -quo_u : quo_u;
    rem   = neg_a ? -rem_u : rem_u;

    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (src_b == '0) begin
        res_hi = src_a;
        res_lo = '1;
      end else if ((op == MD_DIV) && (src_a == MIN_VAL) && (src_b == '1)) begin
        res_hi = '0;
        res_lo = MIN_VAL;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

endmodule

// File: rtl/mdu_pipe.sv
// E-stage multiply/divide unit: latency-modelling controller, shadow result registers
// and the architectural HI/LO pair, with abort for flushing an in-flight op.
module mdu_pipe
  import mdu_pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             abort,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  md_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] shadow_hi, shadow_lo;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             accept;
  logic             commit;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op     (op),
    .src_a  (srcA),
    .src_b  (srcB),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Abort takes priority over the final count, so an abort on the commit edge drops the result.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      MD_IDLE: begin
        if (start && !abort) begin
          accept = 1'b1;
          if (is_md_arith(op)) begin
            state_next = MD_RUN;
            cnt_next   = ((op == MD_DIV) || (op == MD_DIVU)) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
          end
        end
      end
      MD_RUN: begin
        if (abort) begin
          state_next = MD_IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(1)) begin
          commit     = 1'b1;
          state_next = MD_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_hi <= '0;
      shadow_lo <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      if (accept && is_md_arith(op)) begin
        shadow_hi <= res_hi;
        shadow_lo <= res_lo;
      end
      if (commit) begin
        hi <= shadow_hi;
        lo <= shadow_lo;
      end else if (accept && (op == MD_MTHI)) begin
        hi <= srcA;
      end else if (accept && (op == MD_MTLO)) begin
        lo <= srcA;
      end
    end
  end

  assign busy = (state == MD_RUN);

endmodule

// File: tb/tb_mdu_pipe.sv
// Directed testbench for mdu_pipe: latency windows, arithmetic results, special cases,
// moves, abort behaviour, back-to-back issue and asynchronous reset mid-operation.
module tb_mdu_pipe;
  import mdu_pipe_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic         abort;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int pass_cnt = 0;
  int total_cnt = 0;

  mdu_pipe #(.WIDTH(W), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srcA  (srcA),
    .srcB  (srcB),
    .abort (abort),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Called at a falling edge: presents one start for the next rising edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges with busy high; bounded so a stuck unit cannot hang the run.
  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0) $display("[TB] FAIL reset_hi: got %h expected 00000000", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h0) $display("[TB] FAIL reset_lo: got %h expected 00000000", lo); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int n;
    issue(MD_MULT, -32'sd3, 32'd7);
    wait_done(n);
    total_cnt++; if (n != 5) $display("[TB] FAIL mult_busy_cycles: got %0d expected 5", n); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFFFFFF) $display("[TB] FAIL mult_hi: got %h expected ffffffff", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFFFFEB) $display("[TB] FAIL mult_lo: got %h expected ffffffeb", lo); else pass_cnt++;
  endtask

  task automatic test_div;
    int n;
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done(n);
    total_cnt++; if (n != 10) $display("[TB] FAIL divu_busy_cycles: got %0d expected 10", n); else pass_cnt++;
    total_cnt++; if (lo !== 32'd14) $display("[TB] FAIL divu_lo: got %0d expected 14", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd2) $display("[TB] FAIL divu_hi: got %0d expected 2", hi); else pass_cnt++;
    issue(MD_DIV, -32'sd7, 32'd2);
    wait_done(n);
    total_cnt++; if (lo !== 32'hFFFFFFFD) $display("[TB] FAIL div_neg_lo: got %h expected fffffffd", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFFFFFF) $display("[TB] FAIL div_neg_hi: got %h expected ffffffff", hi); else pass_cnt++;
  endtask

  task automatic test_div_special;
    int n;
    issue(MD_DIV, 32'd55, 32'd0);
    wait_done(n);
    total_cnt++; if (lo !== 32'hFFFFFFFF) $display("[TB] FAIL div0_lo: got %h expected ffffffff", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd55) $display("[TB] FAIL div0_hi: got %0d expected 55", hi); else pass_cnt++;
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    total_cnt++; if (lo !== 32'h80000000) $display("[TB] FAIL divovf_lo: got %h expected 80000000", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0) $display("[TB] FAIL divovf_hi: got %h expected 00000000", hi); else pass_cnt++;
  endtask

  task automatic test_move;
    int n;
    issue(MD_MTHI, 32'h0000DEAD, 32'd0);
    total_cnt++; if (hi !== 32'h0000DEAD) $display("[TB] FAIL mthi_hi: got %h expected 0000dead", hi); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL mthi_busy: got %b expected 0", busy); else pass_cnt++;
    start = 1'b1; op = MD_MTLO; srcA = 32'h00001234; srcB = 32'd0;
    @(negedge clk);
    total_cnt++; if (lo !== 32'h00001234) $display("[TB] FAIL mtlo_lo: got %h expected 00001234", lo); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL mtlo_busy: got %b expected 0", busy); else pass_cnt++;
    op = MD_MULTU; srcA = 32'd2; srcB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    total_cnt++; if (n != 5) $display("[TB] FAIL multu_busy_cycles: got %0d expected 5", n); else pass_cnt++;
    total_cnt++; if (lo !== 32'd6) $display("[TB] FAIL multu_lo: got %0d expected 6", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd0) $display("[TB] FAIL multu_hi: got %h expected 00000000", hi); else pass_cnt++;
  endtask

  task automatic test_abort;
    issue(MD_MTHI, 32'h0000AAAA, 32'd0);
    // Abort in the third busy cycle.
    issue(MD_MULT, 32'd4, 32'd4);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
    repeat (6) @(negedge clk);
    total_cnt++; if (hi !== 32'h0000AAAA) $display("[TB] FAIL abort_hi: got %h expected 0000aaaa", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'd6) $display("[TB] FAIL abort_lo: got %h expected 00000006", lo); else pass_cnt++;
    // Abort on the commit edge.
    issue(MD_MULT, 32'd4, 32'd4);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL abort_commit_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (lo !== 32'd6) $display("[TB] FAIL abort_commit_lo: got %h expected 00000006", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0000AAAA) $display("[TB] FAIL abort_commit_hi: got %h expected 0000aaaa", hi); else pass_cnt++;
    // Start and abort together.
    abort = 1'b1;
    issue(MD_MTLO, 32'd77, 32'd0);
    total_cnt++; if (lo !== 32'd6) $display("[TB] FAIL start_abort_mtlo: got %h expected 00000006", lo); else pass_cnt++;
    issue(MD_MULT, 32'd4, 32'd4);
    abort = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL start_abort_mult_busy: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int n;
    issue(MD_MULTU, 32'd5, 32'd6);
    wait_done(n);
    total_cnt++; if (lo !== 32'd30) $display("[TB] FAIL b2b_first_lo: got %0d expected 30", lo); else pass_cnt++;
    issue(MD_DIVU, 32'd31, 32'd4);
    wait_done(n);
    total_cnt++; if (n != 10) $display("[TB] FAIL b2b_busy_cycles: got %0d expected 10", n); else pass_cnt++;
    total_cnt++; if (lo !== 32'd7) $display("[TB] FAIL b2b_lo: got %0d expected 7", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd3) $display("[TB] FAIL b2b_hi: got %0d expected 3", hi); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int n;
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0) $display("[TB] FAIL midreset_hi: got %h expected 00000000", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h0) $display("[TB] FAIL midreset_lo: got %h expected 00000000", lo); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(MD_DIVU, 32'd9, 32'd3);
    wait_done(n);
    total_cnt++; if (n != 10) $display("[TB] FAIL postreset_busy_cycles: got %0d expected 10", n); else pass_cnt++;
    total_cnt++; if (lo !== 32'd3) $display("[TB] FAIL postreset_lo: got %0d expected 3", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd0) $display("[TB] FAIL postreset_hi: got %0d expected 0", hi); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = MD_MULT;
    srcA  = '0;
    srcB  = '0;
    abort = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_special();
    test_move();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
